// File: rtl/notif_pkg.sv
// Shared types and sizing helpers for the notification publisher and its FIFO.
package notif_pkg;

   typedef logic [31:0] notif_msg_t;

   // Width needed to hold a count in the range 0..depth inclusive.
   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/notif_fifo.sv
// Circular-buffer FIFO with val/rdy on both sides. The head is visible
// combinationally on deq_msg whenever deq_val is high.
module notif_fifo
   import notif_pkg::*;
#(
   parameter type t_msg   = notif_msg_t,
   parameter int  p_depth = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [$bits(t_msg)-1:0]   enq_msg,
   input  logic                      enq_val,
   output logic                      enq_rdy,
   output logic [$bits(t_msg)-1:0]   deq_msg,
   output logic                      deq_val,
   input  logic                      deq_rdy,
   output logic [cnt_w(p_depth)-1:0] count
);

   localparam int MW = $bits(t_msg);
   localparam int CW = cnt_w(p_depth);
   localparam int PW = $clog2(p_depth);

   logic [MW-1:0] mem [p_depth];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          enq_fire;
   logic          deq_fire;

   // Full/empty come from the occupancy count, so any depth wraps correctly.
   assign enq_rdy  = (count != CW'(p_depth));
   assign deq_val  = (count != '0);
   assign deq_msg  = mem[rd_ptr];
   assign enq_fire = enq_val & enq_rdy;
   assign deq_fire = deq_rdy & deq_val;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(p_depth - 1)) ? '0 : p + PW'(1);
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (enq_fire) wr_ptr <= next_ptr(wr_ptr);
         if (deq_fire) rd_ptr <= next_ptr(rd_ptr);
         case ({enq_fire, deq_fire})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: entries are only read once count covers them.
   always_ff @(posedge clk) begin
      if (enq_fire) mem[wr_ptr] <= enq_msg;
   end

endmodule

// File: rtl/notif_pub.sv
// Notification publisher: buffers producer messages and emits each as a
// single-cycle pub_val pulse, spaced by at least p_gap idle cycles.
module notif_pub
   import notif_pkg::*;
#(
   parameter type t_msg   = notif_msg_t,
   parameter int  p_depth = 4,
   parameter int  p_gap   = 0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [$bits(t_msg)-1:0]   enq_msg,
   input  logic                      enq_val,
   output logic                      enq_rdy,
   output logic [$bits(t_msg)-1:0]   pub_msg,
   output logic                      pub_val,
   output logic [cnt_w(p_depth)-1:0] pend_cnt
);

   localparam int MW = $bits(t_msg);
   localparam int GW = $clog2(p_gap + 2);

   logic [GW-1:0] gap_cnt;
   logic [MW-1:0] head_msg;
   logic [MW-1:0] pub_src;
   logic          head_val;
   logic          fifo_enq_val;
   logic          fifo_deq_rdy;
   logic          enq_fire;
   logic          gap_open;
   logic          bypass;
   logic          do_pub;

   // Handshake: a message transfers on a posedge where enq_val & enq_rdy.
   // enq_rdy depends only on registered occupancy; the producer holds
   // enq_msg/enq_val stable while enq_rdy is low. pub_val has no ready.
   assign enq_fire     = enq_val & enq_rdy;
   assign gap_open     = (gap_cnt == '0);
   assign bypass       = enq_fire & ~head_val & gap_open;
   assign do_pub       = gap_open & (head_val | enq_fire);
   assign pub_src      = head_val ? head_msg : enq_msg;
   assign fifo_enq_val = enq_val & ~bypass;
   assign fifo_deq_rdy = gap_open & head_val;

   notif_fifo #(
      .t_msg   (t_msg),
      .p_depth (p_depth)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .enq_msg (enq_msg),
      .enq_val (fifo_enq_val),
      .enq_rdy (enq_rdy),
      .deq_msg (head_msg),
      .deq_val (head_val),
      .deq_rdy (fifo_deq_rdy),
      .count   (pend_cnt)
   );

   // pub_msg keeps its last value between pulses; only pub_val qualifies it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pub_val <= 1'b0;
         pub_msg <= '0;
         gap_cnt <= '0;
      end else begin
         pub_val <= do_pub;
         if (do_pub) begin
            pub_msg <= pub_src;
            gap_cnt <= GW'(p_gap);
         end else if (!gap_open) begin
            gap_cnt <= gap_cnt - GW'(1);
         end
      end
   end

endmodule

// File: tb/tb_notif_pub.sv
// Bench for notif_pub: four configurations side by side, one active per test,
// checked against an expected-message queue filled as the producer transfers.
module tb_notif_pub;

   localparam int N_DUT = 4;
   localparam int DEPTH [N_DUT] = '{4, 4, 4, 3};
   localparam int GAP   [N_DUT] = '{0, 2, 3, 1};

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] enq_msg [N_DUT];
   logic        enq_val [N_DUT];
   logic        enq_rdy [N_DUT];
   logic [31:0] pub_msg [N_DUT];
   logic        pub_val [N_DUT];
   logic [2:0]  pend_a, pend_b, pend_c;
   logic [1:0]  pend_d;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          cur      = -1;
   int          cyc      = 0;
   int          last_pulse;
   int          max_pend;
   int          prev_pend;
   int          stalls;
   int          pulse_cyc [$];
   logic [31:0] exp_q [$];

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   notif_pub #(.p_depth(4), .p_gap(0)) u_a (
      .clk(clk), .rst(rst_n), .enq_msg(enq_msg[0]), .enq_val(enq_val[0]), .enq_rdy(enq_rdy[0]),
      .pub_msg(pub_msg[0]), .pub_val(pub_val[0]), .pend_cnt(pend_a));
   notif_pub #(.p_depth(4), .p_gap(2)) u_b (
      .clk(clk), .rst(rst_n), .enq_msg(enq_msg[1]), .enq_val(enq_val[1]), .enq_rdy(enq_rdy[1]),
      .pub_msg(pub_msg[1]), .pub_val(pub_val[1]), .pend_cnt(pend_b));
   notif_pub #(.p_depth(4), .p_gap(3)) u_c (
      .clk(clk), .rst(rst_n), .enq_msg(enq_msg[2]), .enq_val(enq_val[2]), .enq_rdy(enq_rdy[2]),
      .pub_msg(pub_msg[2]), .pub_val(pub_val[2]), .pend_cnt(pend_c));
   notif_pub #(.p_depth(3), .p_gap(1)) u_d (
      .clk(clk), .rst(rst_n), .enq_msg(enq_msg[3]), .enq_val(enq_val[3]), .enq_rdy(enq_rdy[3]),
      .pub_msg(pub_msg[3]), .pub_val(pub_val[3]), .pend_cnt(pend_d));

   function automatic int pend_of(input int i);
      case (i)
         0:       return int'(pend_a);
         1:       return int'(pend_b);
         2:       return int'(pend_c);
         default: return int'(pend_d);
      endcase
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic start_test(input int i);
      cur        = i;
      pulse_cyc.delete();
      max_pend   = 0;
      last_pulse = -1;
      prev_pend  = 0;
      stalls     = 0;
   endtask

   // Present m; it transfers on the posedge after the negedge where enq_rdy is seen high.
   task automatic send(input int i, input logic [31:0] m);
      int budget = 100;
      @(negedge clk);
      enq_msg[i] = m;
      enq_val[i] = 1'b1;
      while (!enq_rdy[i] && budget > 0) begin
         stalls++;
         budget--;
         @(negedge clk);
      end
      if (enq_rdy[i]) exp_q.push_back(m);
      else begin
         check_eq("send_timeout", 32'(enq_rdy[i]), 32'd1);
         enq_val[i] = 1'b0;
      end
   endtask

   task automatic idle(input int i, input int n);
      @(negedge clk);
      enq_val[i] = 1'b0;
      repeat (n - 1) @(negedge clk);
   endtask

   task automatic drain(input int n_extra);
      int budget = 200;
      while (exp_q.size() != 0 && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      check_eq("drain_empty", 32'(exp_q.size()), 32'd0);
      repeat (n_extra) @(negedge clk);
   endtask

   // ---------------- scoreboard / monitor ----------------
   always @(negedge clk) begin : mon
      int pv;
      if (rst_n) begin
         cyc++;
         for (int j = 0; j < N_DUT; j++)
            if (j != cur) check_eq("stray_pulse", 32'(pub_val[j]), 32'd0);
         if (cur >= 0) begin
            pv = pend_of(cur);
            if (pv > max_pend) max_pend = pv;
            check_eq("pend_le_depth", 32'(pv <= DEPTH[cur]), 32'd1);
            if (pv == DEPTH[cur]) check_eq("rdy_low_when_full", 32'(enq_rdy[cur]), 32'd0);
            if (pub_val[cur]) begin
               check_eq("pulse_expected", 32'(exp_q.size() != 0), 32'd1);
               if (exp_q.size() != 0) check_eq("pub_msg_order", pub_msg[cur], exp_q.pop_front());
               if (last_pulse >= 0) check_eq("min_gap", 32'(cyc - last_pulse > GAP[cur]), 32'd1);
               if (prev_pend == DEPTH[cur]) begin
                  check_eq("slot_freed", 32'(pv), 32'(DEPTH[cur] - 1));
                  check_eq("rdy_after_free", 32'(enq_rdy[cur]), 32'd1);
               end
               last_pulse = cyc;
               pulse_cyc.push_back(cyc);
            end
            prev_pend = pv;
         end
      end
   end

   initial begin
      #200000;
      n_fail++;
      $display("FAIL global_timeout: simulation did not complete");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // ---------------- stimulus ----------------
   initial begin
      for (int i = 0; i < N_DUT; i++) begin
         enq_msg[i] = '0;
         enq_val[i] = 1'b0;
      end
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < N_DUT; i++) begin
         check_eq("rst_pub_val", 32'(pub_val[i]), 32'd0);
         check_eq("rst_pub_msg", pub_msg[i], 32'd0);
         check_eq("rst_pend", 32'(pend_of(i)), 32'd0);
         check_eq("rst_enq_rdy", 32'(enq_rdy[i]), 32'd1);
      end

      // single message, bypass latency of one cycle
      start_test(0);
      send(0, 32'hDEADBEEF);
      @(negedge clk);
      enq_val[0] = 1'b0;
      check_eq("t1_pub_val", 32'(pub_val[0]), 32'd1);
      check_eq("t1_pub_msg", pub_msg[0], 32'hDEADBEEF);
      check_eq("t1_pend", 32'(pend_a), 32'd0);
      @(negedge clk);
      check_eq("t1_pub_val_drop", 32'(pub_val[0]), 32'd0);
      drain(3);

      // burst with no gap
      start_test(0);
      for (int k = 1; k <= 5; k++) send(0, 32'(k));
      idle(0, 1);
      drain(4);
      check_eq("t2_no_stall", 32'(stalls), 32'd0);
      check_eq("t2_pulses", 32'(pulse_cyc.size()), 32'd5);
      if (pulse_cyc.size() == 5)
         for (int k = 1; k < 5; k++) check_eq("t2_consecutive", 32'(pulse_cyc[k] - pulse_cyc[k-1]), 32'd1);

      // gap of 2
      start_test(1);
      send(1, 32'hA);
      send(1, 32'hB);
      send(1, 32'hC);
      idle(1, 1);
      drain(6);
      check_eq("t3_pulses", 32'(pulse_cyc.size()), 32'd3);
      check_eq("t3_max_pend", 32'(max_pend), 32'd2);
      if (pulse_cyc.size() == 3)
         for (int k = 1; k < 3; k++) check_eq("t3_spacing", 32'(pulse_cyc[k] - pulse_cyc[k-1]), 32'd3);

      // FIFO fills and producer stalls
      start_test(2);
      for (int k = 0; k < 8; k++) send(2, 32'h100 + 32'(k));
      idle(2, 1);
      drain(8);
      check_eq("t4_stalled", 32'(stalls > 0), 32'd1);
      check_eq("t4_max_pend", 32'(max_pend), 32'd4);
      check_eq("t4_pulses", 32'(pulse_cyc.size()), 32'd8);

      // non-power-of-2 depth with random producer gaps
      start_test(3);
      for (int k = 0; k < 10; k++) begin
         int g;
         send(3, 32'h10 + 32'(k));
         g = $urandom_range(0, 3);
         if (g > 0) idle(3, g);
      end
      idle(3, 1);
      drain(6);
      check_eq("t5_pulses", 32'(pulse_cyc.size()), 32'd10);
      check_eq("t5_max_pend", 32'(max_pend <= 3), 32'd1);

      // async reset mid-stream
      start_test(2);
      for (int k = 0; k < 5; k++) send(2, 32'h200 + 32'(k));
      @(posedge clk);
      #2;
      enq_val[2] = 1'b0;
      check_eq("t6_pre_pub_val", 32'(pub_val[2]), 32'd1);
      check_eq("t6_pre_pend", 32'(pend_c), 32'd3);
      check_eq("t6_pre_pub_msg", pub_msg[2], 32'h201);
      #1;
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      check_eq("t6_rst_pub_val", 32'(pub_val[2]), 32'd0);
      check_eq("t6_rst_pend", 32'(pend_c), 32'd0);
      check_eq("t6_rst_pub_msg", pub_msg[2], 32'd0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      start_test(2);
      @(negedge clk);
      check_eq("t6_rdy_after_rst", 32'(enq_rdy[2]), 32'd1);
      send(2, 32'h77);
      idle(2, 1);
      drain(12);
      check_eq("t6_single_pulse", 32'(pulse_cyc.size()), 32'd1);

      cur = -1;
      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
